int_ram_loader: RTL and testbench

//  Byte-stream command bridge that programs and reads back the internal RAM from outside in embed mode.

---
 rtl/int_ram_loader.sv | 199 +++++++++++++++++++
 tb/tb_int_ram_loader.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/int_ram_loader.sv
// Byte-stream command bridge that writes and reads back a 64x16 internal RAM.
// Frames are CMD, ADDR, CNT, then payload words (write) or streamed readback bytes (read).
module int_ram_loader #(
    parameter int AW = 6,
    parameter int RW = 16
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic [7:0]    i_rx_data,
    input  logic          i_rx_valid,
    output logic          o_rx_ready,
    output logic [7:0]    o_tx_data,
    output logic          o_tx_valid,
    input  logic          i_tx_ready,
    output logic [AW-1:0] o_ram_addr,
    output logic [RW-1:0] o_ram_data,
    output logic          o_ram_we,
    input  logic [RW-1:0] i_ram_data,
    output logic          o_busy
);

    localparam logic [7:0] CMD_WRITE = 8'h57;
    localparam logic [7:0] CMD_READ  = 8'h52;

    typedef enum logic [3:0] {
        S_IDLE,
        S_ADDR,
        S_CNT,
        S_WLO,
        S_WHI,
        S_RREQ,
        S_RWAIT,
        S_TLO,
        S_THI
    } state_t;

    state_t state, state_next;

    logic          is_write_q;
    logic [AW-1:0] addr_q;
    logic [7:0]    count_q;
    logic [7:0]    lo_q;
    logic [RW-1:0] hold_q;
    logic [AW-1:0] ram_addr_q;
    logic [RW-1:0] ram_data_q;
    logic          ram_we_q;

    logic rx_state;
    logic tx_state;
    logic rx_fire;
    logic tx_fire;
    logic last_word;

    // Handshakes are gated by reset so nothing is accepted or offered in the reset cycle.
    always_comb begin
        rx_state   = (state == S_IDLE) || (state == S_ADDR) || (state == S_CNT) ||
                     (state == S_WLO)  || (state == S_WHI);
        tx_state   = (state == S_TLO) || (state == S_THI);
        o_rx_ready = rx_state & ~i_rst;
        o_tx_valid = tx_state & ~i_rst;
        rx_fire    = i_rx_valid & o_rx_ready;
        tx_fire    = o_tx_valid & i_tx_ready;
        last_word  = (count_q == 8'd1);
        o_busy     = (state != S_IDLE);
        o_ram_addr = ram_addr_q;
        o_ram_data = ram_data_q;
        o_ram_we   = ram_we_q & ~i_rst;
    end

    always_comb begin
        o_tx_data = 8'h00;
        if (state == S_TLO) begin
            o_tx_data = hold_q[7:0];
        end else if (state == S_THI) begin
            o_tx_data = hold_q[15:8];
        end
    end

    // NOTE: every combinational output gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (rx_fire && (i_rx_data == CMD_WRITE || i_rx_data == CMD_READ)) begin
                    state_next = S_ADDR;
                end
            end
            S_ADDR: begin
                if (rx_fire) begin
                    state_next = S_CNT;
                end
            end
            S_CNT: begin
                if (rx_fire) begin
                    if (i_rx_data == 8'd0) begin
                        state_next = S_IDLE;
                    end else if (is_write_q) begin
                        state_next = S_WLO;
                    end else begin
                        state_next = S_RREQ;
                    end
                end
            end
            S_WLO: begin
                if (rx_fire) begin
                    state_next = S_WHI;
                end
            end
            S_WHI: begin
                if (rx_fire) begin
                    state_next = last_word ? S_IDLE : S_WLO;
                end
            end
            S_RREQ:  state_next = S_RWAIT;
            S_RWAIT: state_next = S_TLO;
            S_TLO: begin
                if (tx_fire) begin
                    state_next = S_THI;
                end
            end
            S_THI: begin
                if (tx_fire) begin
                    state_next = last_word ? S_IDLE : S_RREQ;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            is_write_q <= 1'b0;
            addr_q     <= '0;
            count_q    <= 8'd0;
            lo_q       <= 8'd0;
            hold_q     <= '0;
            ram_addr_q <= '0;
            ram_data_q <= '0;
            ram_we_q   <= 1'b0;
        end else begin
            ram_we_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (rx_fire) begin
                        is_write_q <= (i_rx_data == CMD_WRITE);
                    end
                end
                S_ADDR: begin
                    if (rx_fire) begin
                        addr_q <= i_rx_data[AW-1:0];
                    end
                end
                S_CNT: begin
                    if (rx_fire) begin
                        count_q    <= i_rx_data;
                        ram_addr_q <= addr_q;
                    end
                end
                S_WLO: begin
                    if (rx_fire) begin
                        lo_q <= i_rx_data;
                    end
                end
                // The write is issued the cycle after the high byte so the next low byte can land meanwhile.
                S_WHI: begin
                    if (rx_fire) begin
                        ram_we_q   <= 1'b1;
                        ram_data_q <= {i_rx_data, lo_q};
                        ram_addr_q <= addr_q;
                        addr_q     <= addr_q + 1'b1;
                        count_q    <= count_q - 8'd1;
                    end
                end
                S_RWAIT: begin
                    hold_q <= i_ram_data;
                end
                S_THI: begin
                    if (tx_fire) begin
                        addr_q     <= addr_q + 1'b1;
                        ram_addr_q <= addr_q + 1'b1;
                        count_q    <= count_q - 8'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_int_ram_loader.sv
// Self-checking bench for int_ram_loader: fixed vector table, corner sequences and random frames
// compared against a frame-level reference model with its own copy of the RAM.
module tb_int_ram_loader;

    localparam int AW = 6;
    localparam int RW = 16;

    typedef logic [7:0] bq_t[$];

    typedef struct {
        string       name;
        logic [7:0]  b[8];
        int          nbytes;
        int          nwr;
        logic [5:0]  wa[2];
        logic [15:0] wd[2];
        int          ntx;
        logic [7:0]  tx[4];
    } vec_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          rx_ready;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_ready;
    logic [AW-1:0] ram_addr;
    logic [RW-1:0] ram_wdata;
    logic          ram_we;
    logic [RW-1:0] ram_rdata;
    logic          busy;

    int errors = 0;
    int checks = 0;
    int wr_seen = 0;
    int tx_seen = 0;
    int pay_stall = 0;
    int tx_mode = 0;
    int stall_cnt = 0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;

    logic [15:0] mem [64];
    logic [15:0] ref_mem [64];
    logic [21:0] exp_wr [$];
    logic [7:0]  exp_tx [$];

    vec_t vt [6];

    always #5 clk = ~clk;

    int_ram_loader #(.AW(AW), .RW(RW)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_rx_data  (rx_data),
        .i_rx_valid (rx_valid),
        .o_rx_ready (rx_ready),
        .o_tx_data  (tx_data),
        .o_tx_valid (tx_valid),
        .i_tx_ready (tx_ready),
        .o_ram_addr (ram_addr),
        .o_ram_data (ram_wdata),
        .o_ram_we   (ram_we),
        .i_ram_data (ram_rdata),
        .o_busy     (busy)
    );

    // Registered-read RAM: data appears one cycle after the address.
    always @(posedge clk) begin
        ram_rdata <= mem[ram_addr];
        if (ram_we) mem[ram_addr] <= ram_wdata;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor and tx sink, evaluated on the falling edge away from the DUT's active edge.
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
            tx_ready   = 1'b0;
        end else begin
            if (prev_stall) check("tx_hold", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, prev_data});
            case (tx_mode)
                0: tx_ready = 1'b1;
                1: tx_ready = 1'($urandom_range(0, 1));
                default: begin
                    if (tx_valid && stall_cnt >= 5) begin
                        tx_ready  = 1'b1;
                        stall_cnt = 0;
                    end else begin
                        tx_ready = 1'b0;
                        if (tx_valid) stall_cnt++;
                    end
                end
            endcase
            if (tx_valid && tx_ready) begin
                tx_seen++;
                if (exp_tx.size() == 0) check("tx_unexpected", 32'(tx_data), 32'hFFFF_FFFF);
                else check("tx_byte", 32'(tx_data), 32'(exp_tx.pop_front()));
            end
            prev_stall = tx_valid && !tx_ready;
            prev_data  = tx_data;
            if (ram_we) begin
                wr_seen++;
                check("we_in_read_state", 32'(busy && !rx_ready), 32'd0);
                if (exp_wr.size() == 0) check("we_unexpected", {10'd0, ram_addr, ram_wdata}, 32'hFFFF_FFFF);
                else check("we_word", {10'd0, ram_addr, ram_wdata}, {10'd0, exp_wr.pop_front()});
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit payload);
        int waits = 0;
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        while (!rx_ready && waits < 3000) begin
            @(negedge clk);
            waits++;
        end
        if (!rx_ready) begin
            check("rx_accept_timeout", 32'd1, 32'd0);
            rx_valid = 1'b0;
            return;
        end
        if (payload) pay_stall += waits;
        @(posedge clk);
        #1 rx_valid = 1'b0;
    endtask

    // Reference: frame-level semantics on a plain array, word addresses wrap modulo 64.
    task automatic model_frame(input logic [7:0] cmd, input logic [7:0] addr, input logic [7:0] cnt, input bq_t pl);
        logic [5:0]  a = addr[5:0];
        logic [15:0] w;
        for (int i = 0; i < int'(cnt); i++) begin
            if (cmd == 8'h57) begin
                w = {pl[2*i+1], pl[2*i]};
                exp_wr.push_back({a, w});
                ref_mem[a] = w;
            end else if (cmd == 8'h52) begin
                exp_tx.push_back(ref_mem[a][7:0]);
                exp_tx.push_back(ref_mem[a][15:8]);
            end
            a = 6'((int'(a) + 1) % 64);
        end
    endtask

    task automatic send_frame(input logic [7:0] cmd, input logic [7:0] addr, input logic [7:0] cnt, input bq_t pl);
        send_byte(cmd, 1'b0);
        if (cmd != 8'h57 && cmd != 8'h52) return;
        send_byte(addr, 1'b0);
        send_byte(cnt, 1'b0);
        if (cmd == 8'h57) foreach (pl[i]) send_byte(pl[i], 1'b1);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((busy || exp_wr.size() != 0 || exp_tx.size() != 0) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        check({name, "_idle"}, {30'd0, busy, 1'b0}, 32'd0);
        check({name, "_drained"}, 32'(exp_wr.size() + exp_tx.size()), 32'd0);
    endtask

    task automatic rand_frame();
        logic [7:0] cmd, addr, cnt;
        bq_t pl;
        int  r = $urandom_range(0, 9);
        if (r < 1) begin
            do cmd = 8'($urandom_range(0, 255)); while (cmd == 8'h57 || cmd == 8'h52);
        end else begin
            cmd = (r < 5) ? 8'h57 : 8'h52;
        end
        addr = 8'($urandom_range(0, 255));
        cnt  = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 5));
        for (int i = 0; i < 2 * int'(cnt); i++) pl.push_back(8'($urandom_range(0, 255)));
        tx_mode = $urandom_range(0, 2);
        model_frame(cmd, addr, cnt, pl);
        send_frame(cmd, addr, cnt, pl);
    endtask

    initial begin
        bq_t pl;
        int  wr0, tx0;

        vt[0] = '{"w_basic",  '{8'h57, 8'h02, 8'h02, 8'h34, 8'h12, 8'h78, 8'h56, 8'h00}, 7,
                  2, '{6'd2, 6'd3},  '{16'h1234, 16'h5678}, 0, '{8'h00, 8'h00, 8'h00, 8'h00}};
        vt[1] = '{"r_basic",  '{8'h52, 8'h02, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 3,
                  0, '{6'd0, 6'd0},  '{16'h0000, 16'h0000}, 4, '{8'h34, 8'h12, 8'h78, 8'h56}};
        vt[2] = '{"w_wrap",   '{8'h57, 8'h3F, 8'h02, 8'hCD, 8'hAB, 8'h01, 8'hEF, 8'h00}, 7,
                  2, '{6'd63, 6'd0}, '{16'hABCD, 16'hEF01}, 0, '{8'h00, 8'h00, 8'h00, 8'h00}};
        vt[3] = '{"r_wrap",   '{8'h52, 8'hFF, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 3,
                  0, '{6'd0, 6'd0},  '{16'h0000, 16'h0000}, 4, '{8'hCD, 8'hAB, 8'h01, 8'hEF}};
        vt[4] = '{"drop_cnt0", '{8'h00, 8'h57, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 4,
                  0, '{6'd0, 6'd0},  '{16'h0000, 16'h0000}, 0, '{8'h00, 8'h00, 8'h00, 8'h00}};
        vt[5] = '{"r_one",    '{8'h52, 8'h40, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 3,
                  0, '{6'd0, 6'd0},  '{16'h0000, 16'h0000}, 2, '{8'h01, 8'hEF, 8'h00, 8'h00}};

        for (int i = 0; i < 64; i++) begin
            mem[i]     = 16'($urandom_range(0, 65535));
            ref_mem[i] = mem[i];
        end

        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        tx_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_rx_ready", 32'(rx_ready), 32'd0);
        check("reset_outputs", {7'd0, busy, tx_valid, tx_data, ram_we, ram_addr, 8'd0},
              32'd0);
        check("reset_ram_data", 32'(ram_wdata), 32'd0);
        rst = 1'b0;
        #1 check("idle_rx_ready", 32'(rx_ready), 32'd1);

        foreach (vt[v]) begin
            for (int i = 0; i < vt[v].nwr; i++) begin
                exp_wr.push_back({vt[v].wa[i], vt[v].wd[i]});
                ref_mem[vt[v].wa[i]] = vt[v].wd[i];
            end
            for (int i = 0; i < vt[v].ntx; i++) exp_tx.push_back(vt[v].tx[i]);
            wr0 = wr_seen;
            tx0 = tx_seen;
            for (int i = 0; i < vt[v].nbytes; i++)
                send_byte(vt[v].b[i], (i >= 3) && (vt[v].b[0] == 8'h57));
            wait_idle(vt[v].name);
            check({vt[v].name, "_nwr"}, 32'(wr_seen - wr0), 32'(vt[v].nwr));
            check({vt[v].name, "_ntx"}, 32'(tx_seen - tx0), 32'(vt[v].ntx));
        end

        // Stalled readback with the next write frame queued behind it on rx.
        tx_mode = 2;
        pl = {};
        model_frame(8'h52, 8'h02, 8'h02, pl);
        send_frame(8'h52, 8'h02, 8'h02, pl);
        pl = {8'h11, 8'h22, 8'h33, 8'h44};
        model_frame(8'h57, 8'h20, 8'h02, pl);
        send_frame(8'h57, 8'h20, 8'h02, pl);
        wait_idle("stall_read");
        tx_mode = 0;

        // Reset while the high byte of a word is pending.
        wr0 = wr_seen;
        send_byte(8'h57, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'hAA, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_rx_ready", 32'(rx_ready), 32'd0);
        check("midrst_we", 32'(ram_we), 32'd0);
        @(posedge clk);
        #1;
        check("midrst_outputs", {7'd0, busy, tx_valid, tx_data, ram_we, ram_addr, 8'd0}, 32'd0);
        check("midrst_ram_data", 32'(ram_wdata), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1 check("midrst_ready_back", 32'(rx_ready), 32'd1);
        pl = {8'h22, 8'h11};
        model_frame(8'h57, 8'h07, 8'h01, pl);
        send_frame(8'h57, 8'h07, 8'h01, pl);
        pl = {};
        model_frame(8'h52, 8'h01, 8'h01, pl);
        send_frame(8'h52, 8'h01, 8'h01, pl);
        wait_idle("after_rst");
        check("after_rst_nwr", 32'(wr_seen - wr0), 32'd1);

        for (int f = 0; f < 40; f++) rand_frame();
        wait_idle("random");
        tx_mode = 0;
        pl = {};
        model_frame(8'h52, 8'h00, 8'd64, pl);
        send_frame(8'h52, 8'h00, 8'd64, pl);
        wait_idle("full_dump");

        check("payload_stall_cycles", 32'(pay_stall), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
